// File: rtl/traffic_light_multi_if.sv
// Lamp/demand bundle for traffic_light_multi; master drives tick/demand, slave is the controller.
// Optional pedestrian signals present when TRAFFIC_PED_WALK_EN is defined.
interface traffic_light_multi_if #(
    parameter int NUM_DIR = 4
);
    localparam int DIR_W = $clog2(NUM_DIR);

    logic               tick;
    logic [NUM_DIR-1:0] demand;
    logic [NUM_DIR-1:0] green;
    logic [NUM_DIR-1:0] yellow;
    logic [NUM_DIR-1:0] red;
    logic [DIR_W-1:0]   active_dir;
    logic [1:0]         phase;
`ifdef TRAFFIC_PED_WALK_EN
    logic               ped_req;
    logic               walk;
`endif

    modport master (
`ifdef TRAFFIC_PED_WALK_EN
        output ped_req,
        input  walk,
`endif
        output tick, demand,
        input  green, yellow, red, active_dir, phase
    );

    modport slave (
`ifdef TRAFFIC_PED_WALK_EN
        input  ped_req,
        output walk,
`endif
        input  tick, demand,
        output green, yellow, red, active_dir, phase
    );
endinterface

// File: rtl/traffic_light_multi.sv
// Multi-approach traffic light: round-robin demand selection, rest-in-green, tick-timed phases.
// Optional pedestrian WALK phase enabled by defining TRAFFIC_PED_WALK_EN.
module traffic_light_multi #(
    parameter int NUM_DIR      = 4,
    parameter int GREEN_TICKS  = 5,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
`ifdef TRAFFIC_PED_WALK_EN
    parameter int WALK_TICKS   = 4,
`endif
    parameter int CNT_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    traffic_light_multi_if.slave  bus
);
    localparam int DIR_W = $clog2(NUM_DIR);

    localparam logic [DIR_W-1:0] DIR_LAST   = DIR_W'(NUM_DIR - 1);
    localparam logic [CNT_W-1:0] GREEN_END  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_END = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_END = CNT_W'(ALLRED_TICKS - 1);
`ifdef TRAFFIC_PED_WALK_EN
    localparam logic [CNT_W-1:0] WALK_END   = CNT_W'(WALK_TICKS - 1);
`endif

    typedef enum logic [1:0] {
        PH_ALL_RED = 2'b00,
        PH_GREEN   = 2'b01,
        PH_YELLOW  = 2'b10,
        PH_WALK    = 2'b11
    } phase_e;

    phase_e             phase_q, phase_nxt;
    logic [DIR_W-1:0]   dir_q, dir_nxt, sel_dir;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [NUM_DIR-1:0] green_q, yellow_q, red_q;
    logic [NUM_DIR-1:0] green_d, yellow_d, red_d;
    logic               other_demand;
`ifdef TRAFFIC_PED_WALK_EN
    logic               pend_q, pend_clr;
    logic               walk_q, walk_d;
`endif

    // First demanding approach after the current one; plain rotation when nobody waits.
    always_comb begin
        int unsigned idx;
        logic        found;
        idx     = 0;
        found   = 1'b0;
        sel_dir = DIR_W'((32'(dir_q) + 1) % NUM_DIR);
        for (int unsigned k = 1; k <= NUM_DIR; k++) begin
            idx = (32'(dir_q) + k) % NUM_DIR;
            if (!found && bus.demand[idx[DIR_W-1:0]]) begin
                sel_dir = idx[DIR_W-1:0];
                found   = 1'b1;
            end
        end
        other_demand = |(bus.demand & ~(NUM_DIR'(1) << dir_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= PH_ALL_RED;
            dir_q    <= DIR_LAST;
            cnt_q    <= '0;
            green_q  <= '0;
            yellow_q <= '0;
            red_q    <= '1;
`ifdef TRAFFIC_PED_WALK_EN
            walk_q   <= 1'b0;
            pend_q   <= 1'b0;
`endif
        end else begin
            phase_q  <= phase_nxt;
            dir_q    <= dir_nxt;
            cnt_q    <= cnt_nxt;
            green_q  <= green_d;
            yellow_q <= yellow_d;
            red_q    <= red_d;
`ifdef TRAFFIC_PED_WALK_EN
            walk_q   <= walk_d;
            pend_q   <= (pend_q & ~pend_clr) | bus.ped_req;
`endif
        end
    end

    always_comb begin
        phase_nxt = phase_q;
        dir_nxt   = dir_q;
        cnt_nxt   = cnt_q;
`ifdef TRAFFIC_PED_WALK_EN
        pend_clr  = 1'b0;
`endif
        if (bus.tick) begin
            cnt_nxt = cnt_q + CNT_W'(1);
            case (phase_q)
                PH_ALL_RED: if (cnt_q == ALLRED_END) begin
                    cnt_nxt = '0;
`ifdef TRAFFIC_PED_WALK_EN
                    if (pend_q) begin
                        phase_nxt = PH_WALK;
                    end else begin
                        phase_nxt = PH_GREEN;
                        dir_nxt   = sel_dir;
                    end
`else
                    phase_nxt = PH_GREEN;
                    dir_nxt   = sel_dir;
`endif
                end
                // Counter parks at GREEN_END so the demand check repeats each tick.
                PH_GREEN: if (cnt_q == GREEN_END) begin
                    if (other_demand) begin
                        phase_nxt = PH_YELLOW;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt   = GREEN_END;
                    end
                end
                PH_YELLOW: if (cnt_q == YELLOW_END) begin
                    phase_nxt = PH_ALL_RED;
                    cnt_nxt   = '0;
                end
`ifdef TRAFFIC_PED_WALK_EN
                PH_WALK: if (cnt_q == WALK_END) begin
                    phase_nxt = PH_ALL_RED;
                    cnt_nxt   = '0;
                    pend_clr  = 1'b1;
                end
`endif
                default: begin
                    phase_nxt = PH_ALL_RED;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Lamps are decoded from the next state and registered alongside it.
    always_comb begin
        green_d  = (phase_nxt == PH_GREEN)  ? (NUM_DIR'(1) << dir_nxt) : '0;
        yellow_d = (phase_nxt == PH_YELLOW) ? (NUM_DIR'(1) << dir_nxt) : '0;
        red_d    = ~(green_d | yellow_d);
`ifdef TRAFFIC_PED_WALK_EN
        walk_d   = (phase_nxt == PH_WALK);
`endif
    end

    assign bus.green      = green_q;
    assign bus.yellow     = yellow_q;
    assign bus.red        = red_q;
    assign bus.active_dir = dir_q;
    assign bus.phase      = phase_q;
`ifdef TRAFFIC_PED_WALK_EN
    assign bus.walk       = walk_q;
`endif
endmodule

// File: tb/tb_traffic_light_multi.sv
// Bench for traffic_light_multi (NUM_DIR=3, 4/2/1 ticks) against a tick-level phase model.
// Pedestrian scenario included when TRAFFIC_PED_WALK_EN is defined.
module tb_traffic_light_multi;
    localparam int N  = 3;
    localparam int GT = 4;
    localparam int YT = 2;
    localparam int AT = 1;
    localparam int WT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    traffic_light_multi_if #(.NUM_DIR(N)) bus();

    traffic_light_multi #(
        .NUM_DIR(N),
        .GREEN_TICKS(GT),
        .YELLOW_TICKS(YT),
        .ALLRED_TICKS(AT),
`ifdef TRAFFIC_PED_WALK_EN
        .WALK_TICKS(WT),
`endif
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model: phase 0 all-red, 1 green, 2 yellow, 3 walk; el = ticks spent in phase.
    int m_phase, m_dir, m_el;
    bit m_pend;

    logic        walk_bit;
    logic [13:0] dut_vec;
`ifdef TRAFFIC_PED_WALK_EN
    assign walk_bit = bus.walk;
`else
    assign walk_bit = 1'b0;
`endif
    assign dut_vec = {bus.green, bus.yellow, bus.red, bus.phase, bus.active_dir, walk_bit};

    function automatic logic [13:0] exp_vec();
        logic [2:0] g, y;
        g = (m_phase == 1) ? 3'(1 << m_dir) : 3'b000;
        y = (m_phase == 2) ? 3'(1 << m_dir) : 3'b000;
        return {g, y, ~(g | y), 2'(m_phase), 2'(m_dir), (m_phase == 3)};
    endfunction

    function automatic int pick_dir(int from, logic [N-1:0] dem);
        for (int k = 1; k <= N; k++)
            if (dem[(from + k) % N]) return (from + k) % N;
        return (from + 1) % N;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_dir = N - 1; m_el = 0; m_pend = 0;
    endtask

    task automatic model_edge(input logic t, input logic [N-1:0] dem, input logic ped);
        bit clr;
        logic [N-1:0] mine;
        clr = 0;
        if (t) begin
            m_el++;
            mine = N'(1 << m_dir);
            case (m_phase)
                0: if (m_el == AT) begin
                    m_el = 0;
                    if (m_pend) m_phase = 3;
                    else begin m_phase = 1; m_dir = pick_dir(m_dir, dem); end
                end
                1: if (m_el >= GT && (dem & ~mine) != 0) begin m_phase = 2; m_el = 0; end
                2: if (m_el == YT) begin m_phase = 0; m_el = 0; end
                default: if (m_el == WT) begin m_phase = 0; m_el = 0; clr = 1; end
            endcase
        end
`ifdef TRAFFIC_PED_WALK_EN
        m_pend = (m_pend && !clr) || ped;
`else
        m_pend = 0;
`endif
    endtask

    task automatic step(input logic t, input logic [N-1:0] dem, input logic ped);
        bus.tick   = t;
        bus.demand = dem;
`ifdef TRAFFIC_PED_WALK_EN
        bus.ped_req = ped;
`endif
        @(posedge clk);
        if (rst_n) model_edge(t, dem, ped);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.tick = 1'b0;
        bus.demand = '0;
`ifdef TRAFFIC_PED_WALK_EN
        bus.ped_req = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.tick = 1'b0;
        bus.demand = '0;
`ifdef TRAFFIC_PED_WALK_EN
        bus.ped_req = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_vec !== {3'b000, 3'b000, 3'b111, 2'b00, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", dut_vec, {3'b000, 3'b000, 3'b111, 2'b00, 2'd2, 1'b0});
        end
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 3'b111, 1'b0);
        checks++;
        if (bus.green !== 3'b001 || bus.active_dir !== 2'd0) begin
            errors++;
            $display("FAIL first_tick green=%b dir=%0d exp green=001 dir=0", bus.green, bus.active_dir);
        end
    endtask

    task automatic test_rotation();
        int order[$];
        int prev_key, run_len, key, exp_len;
        do_reset();
        prev_key = -1; run_len = 0;
        for (int t = 0; t < 24; t++) begin
            for (int c = 0; c < 5; c++) begin
                step(c == 0, 3'b111, 1'b0);
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++;
                    $display("FAIL rotation t=%0d c=%0d got=%b exp=%b", t, c, dut_vec, exp_vec());
                end
                checks++;
                if ($countones(bus.green | bus.yellow) > 1) begin
                    errors++;
                    $display("FAIL rotation_excl g=%b y=%b exp at most one lit", bus.green, bus.yellow);
                end
            end
            key = int'(bus.phase) * 16 + int'(bus.active_dir);
            if (key == prev_key) run_len++;
            else begin
                if (prev_key >= 0) begin
                    exp_len = (prev_key / 16 == 1) ? GT : (prev_key / 16 == 2) ? YT : AT;
                    checks++;
                    if (run_len != exp_len) begin
                        errors++;
                        $display("FAIL rotation_len phase=%0d got=%0d exp=%0d", prev_key / 16, run_len, exp_len);
                    end
                end
                if (bus.phase == 2'b01) order.push_back(int'(bus.active_dir));
                prev_key = key; run_len = 1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= order.size() || order[i] != (i % 3)) begin
                errors++;
                $display("FAIL rotation_order idx=%0d got=%0d exp=%0d", i, (i < order.size()) ? order[i] : -1, i % 3);
            end
        end
    endtask

    task automatic test_skip();
        int order[$];
        int exp_o[4];
        logic [2:0] prev_g;
        exp_o = '{0, 2, 0, 2};
        do_reset();
        prev_g = 3'b000;
        for (int t = 0; t < 24; t++) begin
            step(1'b1, 3'b101, 1'b0);
            checks++;
            if (dut_vec !== exp_vec() || bus.green[1] !== 1'b0) begin
                errors++;
                $display("FAIL skip t=%0d got=%b exp=%b", t, dut_vec, exp_vec());
            end
            if (bus.green != 3'b000 && bus.green != prev_g) order.push_back(int'(bus.active_dir));
            prev_g = bus.green;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= order.size() || order[i] != exp_o[i]) begin
                errors++;
                $display("FAIL skip_order idx=%0d got=%0d exp=%0d", i, (i < order.size()) ? order[i] : -1, exp_o[i]);
            end
        end
    endtask

    task automatic test_rest_in_green();
        do_reset();
        for (int t = 0; t < 12; t++) begin
            step(1'b1, 3'b001, 1'b0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL rest t=%0d got=%b exp=%b", t, dut_vec, exp_vec());
            end
        end
        checks++;
        if (bus.green !== 3'b001) begin
            errors++;
            $display("FAIL rest_hold green=%b exp=001", bus.green);
        end
        step(1'b1, 3'b101, 1'b0);
        checks++;
        if (bus.yellow !== 3'b001 || bus.green !== 3'b000) begin
            errors++;
            $display("FAIL rest_yellow yellow=%b green=%b exp yellow=001 green=000", bus.yellow, bus.green);
        end
        repeat (2) step(1'b1, 3'b101, 1'b0);
        checks++;
        if (bus.red !== 3'b111) begin
            errors++;
            $display("FAIL rest_allred red=%b exp=111", bus.red);
        end
        step(1'b1, 3'b101, 1'b0);
        checks++;
        if (bus.green !== 3'b100 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL rest_next green=%b exp=100", bus.green);
        end
    endtask

    task automatic test_gating_and_async_reset();
        bit found;
        do_reset();
        repeat (3) step(1'b1, 3'b111, 1'b0);
        for (int c = 0; c < 50; c++) begin
            step(1'b0, 3'($urandom_range(0, 7)), 1'b0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL gating c=%0d got=%b exp=%b", c, dut_vec, exp_vec());
            end
        end
        found = 0;
        for (int t = 0; t < 40 && !found; t++) begin
            step(1'b1, 3'b111, 1'b0);
            if (m_phase == 2) found = 1;
        end
        checks++;
        if (!found || bus.yellow == 3'b000) begin
            errors++;
            $display("FAIL reach_yellow yellow=%b exp nonzero", bus.yellow);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.red !== 3'b111 || bus.green !== 3'b000 || bus.yellow !== 3'b000 || bus.phase !== 2'b00) begin
            errors++;
            $display("FAIL async_reset red=%b green=%b yellow=%b phase=%b exp 111/000/000/00",
                     bus.red, bus.green, bus.yellow, bus.phase);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [N-1:0] dem;
        logic t, ped;
        do_reset();
        dem = 3'b111;
        for (int c = 0; c < 400; c++) begin
            t = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) dem = 3'($urandom_range(0, 7));
            ped = ($urandom_range(0, 60) == 0);
            step(t, dem, ped);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random c=%0d got=%b exp=%b", c, dut_vec, exp_vec());
            end
        end
    endtask

`ifdef TRAFFIC_PED_WALK_EN
    task automatic test_walk();
        int walk_cnt;
        bit seen_walk, done;
        logic [2:0] next_green;
        do_reset();
        step(1'b1, 3'b111, 1'b0);
        step(1'b0, 3'b111, 1'b1);
        walk_cnt = 0; seen_walk = 0; done = 0; next_green = 3'b000;
        for (int t = 0; t < 40 && !done; t++) begin
            step(1'b1, 3'b111, 1'b0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL walk t=%0d got=%b exp=%b", t, dut_vec, exp_vec());
            end
            if (bus.walk) begin walk_cnt++; seen_walk = 1; end
            else if (seen_walk && bus.green != 3'b000) begin next_green = bus.green; done = 1; end
        end
        checks++;
        if (walk_cnt != WT || next_green !== 3'b010) begin
            errors++;
            $display("FAIL walk_seq walk_ticks=%0d green=%b exp walk_ticks=%0d green=010", walk_cnt, next_green, WT);
        end
    endtask
`endif

    initial begin
        bus.tick = 1'b0;
        bus.demand = '0;
`ifdef TRAFFIC_PED_WALK_EN
        bus.ped_req = 1'b0;
`endif
        test_reset();
        test_rotation();
        test_skip();
        test_rest_in_green();
        test_gating_and_async_reset();
`ifdef TRAFFIC_PED_WALK_EN
        test_walk();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/traffic_light_multi.md
Name: traffic_light_multi

Overview:
- Parametrised successor of the two-way NS/EW traffic light controller.
- Sequences NUM_DIR approaches through GREEN -> YELLOW -> ALL_RED phases, timed in units of an external tick strobe.
- Adds demand-driven direction selection and rest-in-green.
- Sits beside the tick prescaler; outputs drive lamp drivers directly.

Parameters:
- NUM_DIR, 4, number of approaches (2..8).
- GREEN_TICKS, 5, minimum green duration in ticks (>=1).
- YELLOW_TICKS, 2, yellow duration in ticks (>=1).
- ALLRED_TICKS, 1, all-red clearance duration in ticks (>=1).
- CNT_W, 8, phase counter width; must hold max(GREEN_TICKS, YELLOW_TICKS, ALLRED_TICKS, WALK_TICKS).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  one-cycle timing strobe; every cycle it is high counts one tick.
- demand  input  NUM_DIR  per-direction vehicle demand, level sensitive, sampled on tick.
- green  output  NUM_DIR  per-direction green lamp, at most one bit set.
- yellow  output  NUM_DIR  per-direction yellow lamp, at most one bit set.
- red  output  NUM_DIR  per-direction red lamp.
- active_dir  output  $clog2(NUM_DIR)  index of the current or last served direction.
- phase  output  2  00 ALL_RED, 01 GREEN, 10 YELLOW, 11 WALK.

Behaviour:
- Reset (rst_n low, async):
  - phase=ALL_RED, active_dir=NUM_DIR-1, counter=0.
  - red=all ones; green and yellow all zeros.
  - This makes the first selection search start at direction 0.
- All state changes occur on the rising clk edge in cycles where tick=1. With tick=0, state and counter hold.
- Outputs are registered decodes of the state:
  - red[i] = ~(green[i] | yellow[i]).
  - Lamps for direction d are never simultaneously active.
- Counter:
  - Increments on tick.
  - On the tick where counter == DUR-1 for the current phase, the phase ends and the counter clears to 0.
- ALL_RED ends after ALLRED_TICKS ticks. Next direction selection:
  - Search round-robin from active_dir+1 (mod NUM_DIR) for the first index with demand=1.
  - If no demand anywhere, take active_dir+1 (mod NUM_DIR); fixed cycling.
  - Then go to GREEN.
- GREEN minimum is GREEN_TICKS ticks. At expiry:
  - If any demand[j]=1 with j != active_dir, go to YELLOW.
  - Otherwise rest in GREEN: counter saturates at GREEN_TICKS-1, and the check repeats on every subsequent tick.
- YELLOW lasts YELLOW_TICKS ticks, then goes to ALL_RED.
- Demand on the currently green direction never forces a change.
- Demand changes between ticks are ignored; only the value at a tick edge matters.
- NUM_DIR=2 with demand tied high reproduces the legacy NS/EW cycle.
- Reset mid-phase returns immediately to the reset state; no yellow is shown.

Optional Feature:
- Macro: TRAFFIC_PED_WALK_EN.
- With the macro defined:
  - Adds input ped_req (1 bit) and output walk (1 bit), plus parameter WALK_TICKS (default 4).
  - ped_req is latched into a sticky pending flag on any clk edge where it is high.
  - When ALL_RED ends with pending set, enter WALK instead of GREEN. During WALK: all red, walk=1.
  - After WALK_TICKS ticks: clear pending, enter ALL_RED again, then do normal direction selection.
  - walk resets to 0; pending resets to 0.
- Without the macro:
  - No ped_req/walk ports.
  - Phase encoding 11 is unreachable.

Test Plan:
- Reset check: NUM_DIR=3, GREEN_TICKS=4, YELLOW_TICKS=2, ALLRED_TICKS=1; hold rst_n=0 -> red=3'b111, green=0, yellow=0, phase=00. Release, demand=3'b111, first tick -> green=3'b001, active_dir=0.
- Full rotation, same parameters, demand=3'b111, tick every 5 cycles:
  - Per direction: 4 ticks green, 2 yellow, 1 all-red.
  - Order is 0,1,2,0.
  - Never more than one non-red lamp.
- Skip: demand=3'b101 -> direction 1 never goes green; order is 0,2,0,2.
- Rest-in-green: demand=3'b001 -> direction 0 stays green beyond 4 ticks. Assert demand[2]=1 -> on the next tick yellow=3'b001, then 2 ticks later all red, then green=3'b100.
- Tick gating and async reset: tick held 0 for 50 cycles -> state frozen. Assert rst_n low mid-YELLOW, asynchronously between clk edges -> outputs go to all red without waiting for a clock edge.
- With TRAFFIC_PED_WALK_EN: pulse ped_req for 1 cycle during green on direction 0 -> after yellow and all-red, walk=1 for 4 ticks, then all-red 1 tick, then green=3'b010.
